// File: rtl/multicycle_control_if.sv
// ---------------------------------------------------------------------------
// multicycle_control_if
// Groups the controller's instruction inputs, memory handshake and datapath
// control outputs into one bundle.
//   master : the controller (drives strobes/selects, reads opcode/zero/ready)
//   slave  : the datapath/memory side (drives opcode/zero/ready)
// Signals:
//   opcode[6:0]  instruction opcode from the instruction register
//   zero         ALU zero flag
//   mem_ready    memory access completion
//   mem_req      memory request        mem_we     memory write
//   ir_we        IR/old-PC load        pc_we      PC write
//   pc_src       0=PC+4, 1=target      reg_we     register-file write
//   alu_src_b    0=rs2, 1=immediate    alu_op[1:0] 00 add, 01 sub, 10 funct
//   wb_sel[1:0]  00 ALU, 01 mem, 10 PC+4, 11 immediate
//   state[2:0]   current controller state (debug)
//   fault        sticky fault flag
// ---------------------------------------------------------------------------
interface multicycle_control_if;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       ir_we;
    logic       pc_we;
    logic       pc_src;
    logic       reg_we;
    logic       alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] wb_sel;
    logic [2:0] state;
    logic       fault;

    modport master (
        input  opcode, zero, mem_ready,
        output mem_req, mem_we, ir_we, pc_we, pc_src, reg_we,
               alu_src_b, alu_op, wb_sel, state, fault
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  mem_req, mem_we, ir_we, pc_we, pc_src, reg_we,
               alu_src_b, alu_op, wb_sel, state, fault
    );
endinterface

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
// Control FSM for a multicycle RISC-V style datapath. Sequences each
// instruction through FETCH -> DECODE -> EXEC -> [MEM] -> [WB] and guards
// every memory access with a wait-cycle watchdog that drops into a sticky
// FAULT state if memory never answers.
// Ports:
//   clk      system clock, all state changes on the rising edge
//   rst      synchronous active-high reset; also forces all strobes low
//   ctrlBus  multicycle_control_if.master (opcode/zero/mem_ready in,
//            strobes, selects, debug state and fault out)
// Parameter:
//   MAX_WAIT consecutive unanswered request cycles tolerated before FAULT
// ---------------------------------------------------------------------------
module multicycle_control #(
    parameter int MAX_WAIT = 15
) (
    input  logic                        clk,
    input  logic                        rst,
    multicycle_control_if.master        ctrlBus
);

    // Counter must hold at least MAX_WAIT and is never narrower than 4 bits.
    localparam int CW = ($clog2(MAX_WAIT + 1) < 4) ? 4 : $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic [6:0]      r_opcode;
    logic [CW-1:0]   r_waitCnt;
    logic            r_fault;

    logic            w_timeout;
    logic            w_memReq;
    logic            w_memWe;
    logic            w_irWe;
    logic            w_pcWe;
    logic            w_pcSrc;
    logic            w_regWe;
    logic            w_aluSrcB;
    logic [1:0]      w_aluOp;
    logic [1:0]      w_wbSel;

    function automatic logic isLegal(input logic [6:0] op);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR, OP_JAL, OP_LUI: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // The count reflects unanswered cycles already spent; if this cycle is
    // also unanswered it is the MAX_WAIT-th one and the watchdog trips.
    assign w_timeout = (r_waitCnt >= WAIT_LAST);

    // Next-state and output decode. Memory handshakes check mem_ready before
    // the watchdog so a response in the last allowed cycle still completes.
    always_comb begin
        w_nextState = r_state;
        w_memReq    = 1'b0;
        w_memWe     = 1'b0;
        w_irWe      = 1'b0;
        w_pcWe      = 1'b0;
        w_pcSrc     = 1'b0;
        w_regWe     = 1'b0;
        w_aluSrcB   = 1'b0;
        w_aluOp     = 2'b00;
        w_wbSel     = 2'b00;

        case (r_state)
            S_FETCH: begin
                w_memReq = 1'b1;
                if (ctrlBus.mem_ready) begin
                    w_irWe      = 1'b1;
                    w_pcWe      = 1'b1;
                    w_pcSrc     = 1'b0;
                    w_nextState = S_DECODE;
                end else if (w_timeout) begin
                    w_nextState = S_FAULT;
                end
            end

            S_DECODE: begin
                w_nextState = isLegal(ctrlBus.opcode) ? S_EXEC : S_FAULT;
            end

            S_EXEC: begin
                case (r_opcode)
                    OP_R: begin
                        w_aluSrcB   = 1'b0;
                        w_aluOp     = 2'b10;
                        w_nextState = S_WB;
                    end
                    OP_I: begin
                        w_aluSrcB   = 1'b1;
                        w_aluOp     = 2'b10;
                        w_nextState = S_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        w_aluSrcB   = 1'b1;
                        w_aluOp     = 2'b00;
                        w_nextState = S_MEM;
                    end
                    OP_BR: begin
                        w_aluOp     = 2'b01;
                        w_pcWe      = ctrlBus.zero;
                        w_pcSrc     = 1'b1;
                        w_nextState = S_FETCH;
                    end
                    OP_JAL: begin
                        w_regWe     = 1'b1;
                        w_wbSel     = 2'b10;
                        w_pcWe      = 1'b1;
                        w_pcSrc     = 1'b1;
                        w_nextState = S_FETCH;
                    end
                    OP_LUI: begin
                        w_nextState = S_WB;
                    end
                    default: begin
                        w_nextState = S_FAULT;
                    end
                endcase
            end

            S_MEM: begin
                w_memReq = 1'b1;
                w_memWe  = (r_opcode == OP_STORE);
                if (ctrlBus.mem_ready) begin
                    if (r_opcode == OP_STORE) begin
                        w_nextState = S_FETCH;
                    end else if (r_opcode == OP_LOAD) begin
                        w_nextState = S_WB;
                    end else begin
                        w_nextState = S_FAULT;
                    end
                end else if (w_timeout) begin
                    w_nextState = S_FAULT;
                end
            end

            S_WB: begin
                w_regWe = 1'b1;
                if (r_opcode == OP_LOAD) begin
                    w_wbSel = 2'b01;
                end else if (r_opcode == OP_LUI) begin
                    w_wbSel = 2'b11;
                end else begin
                    w_wbSel = 2'b00;
                end
                w_nextState = S_FETCH;
            end

            S_FAULT: begin
                w_nextState = S_FAULT;
            end

            default: begin
                w_nextState = S_FAULT;
            end
        endcase

        // Reset must silence every strobe in the same cycle it is seen.
        if (rst) begin
            w_memReq = 1'b0;
            w_memWe  = 1'b0;
            w_irWe   = 1'b0;
            w_pcWe   = 1'b0;
            w_regWe  = 1'b0;
        end
    end

    // State register, opcode latch, watchdog counter and sticky fault.
    // The opcode is captured on the DECODE cycle so later instruction-register
    // changes cannot alter EXEC/MEM/WB behaviour.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_opcode  <= 7'd0;
            r_waitCnt <= '0;
            r_fault   <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (r_state == S_DECODE) begin
                r_opcode <= ctrlBus.opcode;
            end
            if (w_nextState != r_state) begin
                r_waitCnt <= '0;
            end else if (w_memReq && !ctrlBus.mem_ready) begin
                r_waitCnt <= r_waitCnt + 1'b1;
            end else begin
                r_waitCnt <= '0;
            end
            r_fault <= (w_nextState == S_FAULT);
        end
    end

    assign ctrlBus.mem_req   = w_memReq;
    assign ctrlBus.mem_we    = w_memWe;
    assign ctrlBus.ir_we     = w_irWe;
    assign ctrlBus.pc_we     = w_pcWe;
    assign ctrlBus.pc_src    = w_pcSrc;
    assign ctrlBus.reg_we    = w_regWe;
    assign ctrlBus.alu_src_b = w_aluSrcB;
    assign ctrlBus.alu_op    = w_aluOp;
    assign ctrlBus.wb_sel    = w_wbSel;
    assign ctrlBus.state     = r_state;
    assign ctrlBus.fault     = r_fault;

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
// Drives instruction sequences into multicycle_control and compares every
// cycle against a per-instruction schedule built from the instruction
// class rules: which phases an instruction visits, how long memory stalls,
// and which controls each phase must show.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

    localparam int MAXW = 15;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    // One expected clock cycle; -1 in a select field means "no requirement".
    typedef struct {
        int         instrNo;
        logic       rdy;
        logic       zr;
        logic [6:0] op;
        int         st;
        int         memReq;
        int         memWe;
        int         irWe;
        int         pcWe;
        int         regWe;
        int         fault;
        int         pcSrc;
        int         aluSrcB;
        int         aluOp;
        int         wbSel;
    } cyc_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    multicycle_control_if bus();

    multicycle_control #(.MAX_WAIT(MAXW)) dut (
        .clk     (clk),
        .rst     (rst),
        .ctrlBus (bus.master)
    );

    always #5 clk = ~clk;

    int   assertCount = 0;
    int   failCount   = 0;
    int   curInstr    = 0;
    cyc_t planQ[$];
    logic [6:0] legalOps [7] = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR, OP_JAL, OP_LUI};

    function automatic bit isLegalOp(input logic [6:0] op);
        for (int i = 0; i < 7; i++) begin
            if (legalOps[i] == op) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic cyc_t blank(input int st);
        cyc_t c;
        c.instrNo = curInstr;
        c.rdy     = 1'($urandom_range(0, 1));
        c.zr      = 1'($urandom_range(0, 1));
        c.op      = 7'($urandom_range(0, 127));
        c.st      = st;
        c.memReq  = 0;
        c.memWe   = 0;
        c.irWe    = 0;
        c.pcWe    = 0;
        c.regWe   = 0;
        c.fault   = (st == 5) ? 1 : 0;
        c.pcSrc   = -1;
        c.aluSrcB = -1;
        c.aluOp   = -1;
        c.wbSel   = -1;
        return c;
    endfunction

    task automatic checkOutput(input int instrNo, input int st, input string field,
                               input logic [7:0] obs, input int exp);
        if (exp >= 0) begin
            assertCount++;
            assert (obs === 8'(exp)) else begin
                failCount++;
                $error("[TB] FAIL instr%0d/st%0d/%s: observed %0d expected %0d",
                       instrNo, st, field, obs, exp);
            end
        end
    endtask

    // Schedule one instruction. fw/mw are the number of cycles memory stays
    // silent in FETCH/MEM; MAXW or more silent cycles end in FAULT.
    // abortInMem stops the schedule after two MEM stall cycles.
    task automatic addInstr(input logic [6:0] opc, input logic zv,
                            input int fw, input int mw, input bit abortInMem);
        cyc_t c;
        bit   isMem;
        curInstr++;
        for (int i = 0; i < fw && i < MAXW; i++) begin
            c = blank(0); c.rdy = 1'b0; c.memReq = 1; c.memWe = 0;
            planQ.push_back(c);
        end
        if (fw >= MAXW) begin
            planQ.push_back(blank(5));
            return;
        end
        c = blank(0); c.rdy = 1'b1; c.memReq = 1; c.memWe = 0;
        c.irWe = 1; c.pcWe = 1; c.pcSrc = 0;
        planQ.push_back(c);
        c = blank(1); c.op = opc;
        planQ.push_back(c);
        if (!isLegalOp(opc)) begin
            planQ.push_back(blank(5));
            return;
        end
        c = blank(2);
        case (opc)
            OP_R:              begin c.aluSrcB = 0; c.aluOp = 2; end
            OP_I:              begin c.aluSrcB = 1; c.aluOp = 2; end
            OP_LOAD, OP_STORE: begin c.aluSrcB = 1; c.aluOp = 0; end
            OP_BR:             begin c.zr = zv; c.aluOp = 1; c.pcWe = int'(zv); c.pcSrc = 1; end
            OP_JAL:            begin c.regWe = 1; c.wbSel = 2; c.pcWe = 1; c.pcSrc = 1; end
            default:           begin end
        endcase
        planQ.push_back(c);
        isMem = (opc == OP_LOAD) || (opc == OP_STORE);
        if (isMem) begin
            for (int i = 0; i < mw && i < MAXW; i++) begin
                c = blank(3); c.rdy = 1'b0; c.memReq = 1; c.memWe = (opc == OP_STORE) ? 1 : 0;
                planQ.push_back(c);
                if (abortInMem && i == 1) return;
            end
            if (mw >= MAXW) begin
                planQ.push_back(blank(5));
                return;
            end
            c = blank(3); c.rdy = 1'b1; c.memReq = 1; c.memWe = (opc == OP_STORE) ? 1 : 0;
            planQ.push_back(c);
        end
        if (opc == OP_STORE || opc == OP_BR || opc == OP_JAL) return;
        c = blank(4); c.regWe = 1;
        c.wbSel = (opc == OP_LOAD) ? 1 : ((opc == OP_LUI) ? 3 : 0);
        planQ.push_back(c);
    endtask

    task automatic addHold(input int n);
        for (int i = 0; i < n; i++) planQ.push_back(blank(5));
    endtask

    task automatic applyStimulus(input cyc_t c);
        @(negedge clk);
        rst           = 1'b0;
        bus.opcode    = c.op;
        bus.zero      = c.zr;
        bus.mem_ready = c.rdy;
        #1;
        checkOutput(c.instrNo, c.st, "state",     8'(bus.state),     c.st);
        checkOutput(c.instrNo, c.st, "mem_req",   8'(bus.mem_req),   c.memReq);
        checkOutput(c.instrNo, c.st, "mem_we",    8'(bus.mem_we),    c.memWe);
        checkOutput(c.instrNo, c.st, "ir_we",     8'(bus.ir_we),     c.irWe);
        checkOutput(c.instrNo, c.st, "pc_we",     8'(bus.pc_we),     c.pcWe);
        checkOutput(c.instrNo, c.st, "reg_we",    8'(bus.reg_we),    c.regWe);
        checkOutput(c.instrNo, c.st, "fault",     8'(bus.fault),     c.fault);
        checkOutput(c.instrNo, c.st, "pc_src",    8'(bus.pc_src),    c.pcSrc);
        checkOutput(c.instrNo, c.st, "alu_src_b", 8'(bus.alu_src_b), c.aluSrcB);
        checkOutput(c.instrNo, c.st, "alu_op",    8'(bus.alu_op),    c.aluOp);
        checkOutput(c.instrNo, c.st, "wb_sel",    8'(bus.wb_sel),    c.wbSel);
    endtask

    task automatic runPlan();
        cyc_t c;
        while (planQ.size() > 0) begin
            c = planQ.pop_front();
            applyStimulus(c);
        end
    endtask

    // Hold reset for n cycles with memory claiming ready; strobes must stay
    // low throughout and state/fault must read as cleared once an edge passed.
    task automatic doReset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst           = 1'b1;
            bus.mem_ready = 1'b1;
            bus.zero      = 1'($urandom_range(0, 1));
            bus.opcode    = 7'($urandom_range(0, 127));
            #1;
            checkOutput(-1, i, "rst_mem_req", 8'(bus.mem_req), 0);
            checkOutput(-1, i, "rst_mem_we",  8'(bus.mem_we),  0);
            checkOutput(-1, i, "rst_ir_we",   8'(bus.ir_we),   0);
            checkOutput(-1, i, "rst_pc_we",   8'(bus.pc_we),   0);
            checkOutput(-1, i, "rst_reg_we",  8'(bus.reg_we),  0);
            if (i > 0) begin
                checkOutput(-1, i, "rst_state", 8'(bus.state), 0);
                checkOutput(-1, i, "rst_fault", 8'(bus.fault), 0);
            end
        end
    endtask

    initial begin
        int fw;
        int mw;
        bus.opcode    = 7'd0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;

        // Basic R-type walk through FETCH, DECODE, EXEC, WB.
        doReset(2);
        addInstr(OP_R, 1'b0, 0, 0, 1'b0);
        runPlan();

        // LOAD with a three-cycle memory stall, then the branch pair.
        addInstr(OP_LOAD, 1'b0, 0, 3, 1'b0);
        addInstr(OP_BR,   1'b1, 0, 0, 1'b0);
        addInstr(OP_BR,   1'b0, 0, 0, 1'b0);
        runPlan();

        // Remaining classes, with stalls in fetch and memory.
        addInstr(OP_JAL,   1'b0, 2, 0, 1'b0);
        addInstr(OP_STORE, 1'b0, 1, 2, 1'b0);
        addInstr(OP_LUI,   1'b0, 0, 0, 1'b0);
        addInstr(OP_I,     1'b0, 3, 0, 1'b0);
        runPlan();

        // Ready arriving on the last allowed cycle completes normally.
        addInstr(OP_R,     1'b0, MAXW - 1, 0,        1'b0);
        addInstr(OP_LOAD,  1'b0, 0,        MAXW - 1, 1'b0);
        addInstr(OP_STORE, 1'b0, MAXW - 1, MAXW - 1, 1'b0);
        runPlan();

        // Randomized legal instruction stream.
        for (int k = 0; k < 40; k++) begin
            fw = ($urandom_range(0, 9) == 0) ? MAXW - 1 : int'($urandom_range(0, 3));
            mw = ($urandom_range(0, 9) == 0) ? MAXW - 1 : int'($urandom_range(0, 3));
            addInstr(legalOps[$urandom_range(0, 6)], 1'($urandom_range(0, 1)), fw, mw, 1'b0);
        end
        runPlan();

        // Fetch watchdog: MAXW silent cycles, then sticky FAULT until reset.
        addInstr(OP_R, 1'b0, MAXW, 0, 1'b0);
        addHold(4);
        runPlan();
        doReset(1);
        addInstr(OP_LUI, 1'b0, 0, 0, 1'b0);
        runPlan();

        // Memory watchdog in MEM.
        addInstr(OP_LOAD, 1'b0, 0, MAXW, 1'b0);
        addHold(2);
        runPlan();
        doReset(1);

        // Illegal opcode faults straight out of DECODE.
        addInstr(7'b1111111, 1'b0, 0, 0, 1'b0);
        addHold(3);
        runPlan();
        doReset(1);

        // Reset in the middle of a stalled STORE returns to FETCH.
        addInstr(OP_STORE, 1'b0, 0, 5, 1'b1);
        runPlan();
        doReset(1);
        addInstr(OP_JAL, 1'b0, 0, 0, 1'b0);
        runPlan();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
